uart_tx: RTL and testbench

- Serial UART transmitter that sits directly downstream of the UART configuration block and consumes its parity_bit_config / stop_bit_config outputs.
- Accepts parallel bytes on a valid/ready handshake and shifts each out LSB-first on a single tx line.
- Frame format: start bit, data bits, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from an internal clock-divider counter; there is no external baud clock.

---
 rtl/uart_tx_pkg.sv | 42 ++++
 rtl/uart_baud_tick.sv | 49 ++++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared UART definitions: FSM state encoding, parity and
//             stop-bit modes, default bit timing and a parity helper.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Transmitter state encoding (3-bit)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_e;

    // Parity mode as latched for one frame
    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    // Stop-bit count as latched for one frame
    localparam logic STOPBITS_1 = 1'b0;
    localparam logic STOPBITS_2 = 1'b1;

    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Widest data word the transmitter supports
    localparam int MAX_WIDTH_DATA = 9;

    // Parity bit for a zero-extended data word; odd=1 makes the total
    // count of ones (data plus parity) odd, odd=0 makes it even.
    function automatic logic calc_parity(input logic [MAX_WIDTH_DATA-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//             emits a one-cycle tick on the terminal count, then wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WIDTH_CNT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [WIDTH_CNT-1:0] TERMINAL = WIDTH_CNT'(CLKS_PER_BIT - 1);

    logic [WIDTH_CNT-1:0] cnt_q;
    logic [WIDTH_CNT-1:0] cnt_d;
    logic                 at_terminal;

    assign at_terminal = (cnt_q == TERMINAL);

    // Next count: clear wins over enable, wrap at the terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_terminal ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && at_terminal;

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter. Accepts a word on a valid/ready handshake and
//             sends start, data (LSB first), optional parity and 1 or 2 stop
//             bits on a registered, idle-high tx line.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int WIDTH_DATA   = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WIDTH_CNT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_DATA-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  parity_bit_config,
    input  logic                  parity_odd,
    input  logic                  stop_bit_config,
    output logic                  tx,
    output logic                  busy
);

    localparam int                 WIDTH_BIT = $clog2(WIDTH_DATA);
    localparam logic [WIDTH_BIT-1:0] LAST_BIT = WIDTH_BIT'(WIDTH_DATA - 1);

    uart_state_e           state_q,       state_d;
    logic [WIDTH_DATA-1:0] shift_q,       shift_d;
    logic [WIDTH_BIT-1:0]  bit_cnt_q,     bit_cnt_d;
    logic [1:0]            parity_mode_q, parity_mode_d;
    logic                  stop_bits_q,   stop_bits_d;
    logic                  parity_bit_q,  parity_bit_d;
    logic                  tx_q,          tx_d;
    logic                  tx_ready_q,    tx_ready_d;
    logic                  busy_q,        busy_d;

    logic                  tick;
    logic                  accept;
    logic [1:0]            in_parity_mode;

    // Bit timer runs only while a frame is in flight; held cleared in IDLE
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .WIDTH_CNT    (WIDTH_CNT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    assign accept         = tx_valid && tx_ready_q;
    assign in_parity_mode = !parity_bit_config ? PARITY_NONE :
                            (parity_odd ? PARITY_ODD : PARITY_EVEN);

    // Next-state, frame capture and next registered outputs
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        parity_mode_d = parity_mode_q;
        stop_bits_d   = stop_bits_q;
        parity_bit_d  = parity_bit_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Everything the frame depends on is frozen here so later
                    // config changes only affect the following frame.
                    shift_d       = tx_data;
                    bit_cnt_d     = '0;
                    parity_mode_d = in_parity_mode;
                    stop_bits_d   = stop_bit_config ? STOPBITS_2 : STOPBITS_1;
                    parity_bit_d  = calc_parity(MAX_WIDTH_DATA'(tx_data),
                                                in_parity_mode == PARITY_ODD);
                    state_d       = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (parity_mode_q != PARITY_NONE) ? PARITY : STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP1;
            end
            STOP1: begin
                if (tick) state_d = (stop_bits_q == STOPBITS_2) ? STOP2 : IDLE;
            end
            STOP2: begin
                if (tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx is a clean flop
        // output and the start bit appears the cycle after acceptance.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_bit_q;
            default: tx_d = 1'b1;
        endcase

        tx_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            parity_mode_q <= PARITY_NONE;
            stop_bits_q   <= STOPBITS_1;
            parity_bit_q  <= 1'b0;
            tx_q          <= 1'b1;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            parity_mode_q <= parity_mode_d;
            stop_bits_q   <= stop_bits_d;
            parity_bit_q  <= parity_bit_d;
            tx_q          <= tx_d;
            tx_ready_q    <= tx_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q && !rst;
    assign busy     = busy_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Scoreboard bench for uart_tx. Stimulus pushes the expected
//             serial frame at acceptance; a line monitor checks every clock
//             of each frame plus the idle gap that follows it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          len;
        logic [7:0]  data;
    } frame_t;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       parity_bit_config;
    logic       parity_odd;
    logic       stop_bit_config;
    logic       tx;
    logic       busy;

    int total;
    int bad;
    int sent;
    int frames_done;

    frame_t exp_q[$];

    uart_tx #(
        .WIDTH_DATA   (8),
        .CLKS_PER_BIT (CPB),
        .WIDTH_CNT    (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .parity_bit_config (parity_bit_config),
        .parity_odd        (parity_odd),
        .stop_bit_config   (stop_bit_config),
        .tx                (tx),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: list of line levels, one per bit period
    function automatic frame_t make_frame(input logic [7:0] d, input logic pen,
                                          input logic podd, input logic s2);
        frame_t f;
        int     n;
        int     ones;
        f.bits = '1;
        n      = 0;
        ones   = 0;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            ones += int'(d[i]);
            n++;
        end
        if (pen) begin
            // choose the bit that makes the total ones even (podd=0) or odd
            f.bits[n] = ((ones % 2) != int'(podd));
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len  = n;
        f.data = d;
        return f;
    endfunction

    task automatic send(input logic [7:0] d, input logic pen,
                        input logic podd, input logic s2);
        int waited;
        tx_data           = d;
        parity_bit_config = pen;
        parity_odd        = podd;
        stop_bit_config   = s2;
        tx_valid          = 1'b1;
        waited            = 0;
        @(negedge clk);
        while (!(tx_ready === 1'b1 && rst === 1'b0) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: data=%h not accepted, tx_ready=%b want 1", d, tx_ready);
            tx_valid = 1'b0;
        end else begin
            exp_q.push_back(make_frame(d, pen, podd, s2));
            sent++;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && tx === 1'b1 && exp_q.size() == 0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%b queued=%0d want busy=0 queued=0", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Line monitor: pops the expected frame at each start bit and checks
    // tx, busy and tx_ready on every clock of the frame and the gap after it
    initial begin : monitor
        frame_t f;
        int     errs;
        int     first_c;
        logic   got_tx;
        logic   got_busy;
        logic   got_rdy;
        bit     pending;
        bit     aborted;
        pending = 1'b0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 1'b0;
            if (rst === 1'b0 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: tx=0 with no frame queued at %0t, want tx=1", $time);
                    for (int k = 0; k < 200 && tx !== 1'b1; k++) @(negedge clk);
                end else begin
                    f        = exp_q.pop_front();
                    errs     = 0;
                    first_c  = -1;
                    aborted  = 1'b0;
                    got_tx   = 1'b0;
                    got_busy = 1'b0;
                    got_rdy  = 1'b0;
                    for (int c = 0; c < f.len * CPB; c++) begin
                        if (c != 0) @(negedge clk);
                        if (rst !== 1'b0) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== f.bits[c / CPB] || busy !== 1'b1 || tx_ready !== 1'b0) begin
                            if (errs == 0) begin
                                first_c  = c;
                                got_tx   = tx;
                                got_busy = busy;
                                got_rdy  = tx_ready;
                            end
                            errs++;
                        end
                    end
                    if (!aborted) begin
                        total++;
                        if (errs != 0)
                            $display("FAIL frame data=%h len=%0d: %0d bad cycles, first at cycle %0d got tx=%b busy=%b ready=%b want tx=%b busy=1 ready=0",
                                     f.data, f.len, errs, first_c, got_tx, got_busy, got_rdy,
                                     f.bits[first_c / CPB]);
                        if (errs != 0) bad++;
                        @(negedge clk);
                        if (rst === 1'b0) begin
                            frames_done++;
                            total++;
                            if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
                                bad++;
                                $display("FAIL frame_end data=%h: got tx=%b busy=%b ready=%b want tx=1 busy=0 ready=1",
                                         f.data, tx, busy, tx_ready);
                            end
                            if (tx_valid === 1'b1) begin
                                @(negedge clk);
                                total++;
                                if (tx !== 1'b0) begin
                                    bad++;
                                    $display("FAIL b2b_gap: got tx=%b one clock after idle, want start bit 0", tx);
                                end else begin
                                    pending = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized frames
    initial begin : stimulus
        logic [7:0] d;
        logic       pen;
        logic       podd;
        logic       s2;
        total             = 0;
        bad               = 0;
        sent              = 0;
        frames_done       = 0;
        rst               = 1'b1;
        tx_data           = '0;
        tx_valid          = 1'b0;
        parity_bit_config = 1'b0;
        parity_odd        = 1'b0;
        stop_bit_config   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;

        // basic, even parity with two stops, odd parity pair
        send(8'hA5, 1'b0, 1'b0, 1'b0); wait_idle();
        send(8'hA5, 1'b1, 1'b0, 1'b1); wait_idle();
        send(8'h07, 1'b1, 1'b1, 1'b0); wait_idle();
        send(8'h03, 1'b1, 1'b1, 1'b0); wait_idle();

        // config changes during DATA must not alter the current frame
        send(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        stop_bit_config   = 1'b1;
        parity_bit_config = 1'b1;
        wait_idle();
        send(8'h55, 1'b1, 1'b0, 1'b1); wait_idle();

        // back-to-back with tx_valid held high
        send(8'h11, 1'b0, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0, 1'b0);
        wait_idle();

        // reset during data bit 3 aborts the frame
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sent--;
        @(negedge clk);
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL abort_tx: got %b want 1", tx); end
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", tx_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        send(8'hF0, 1'b0, 1'b0, 1'b0); wait_idle();

        // randomized data and configuration, random spacing
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            s2   = 1'($urandom);
            send(d, pen, podd, s2);
            if ($urandom_range(0, 3) == 0) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d frames still queued, want 0", exp_q.size());
        end
        total++;
        if (frames_done != sent) begin
            bad++;
            $display("FAIL frame_count: got %0d frames on tx, want %0d", frames_done, sent);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin : watchdog
        #500000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
